multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  7  instr[6:0] from the instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30], passed through for ALU decode.
REQ-007 zero  in  1  ALU zero flag, valid in the BEQ state.
REQ-008 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-009 mem_read, mem_write  out  1 each  memory strobes, held until mem_ready.
REQ-010 adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 ir_write, pc_write, reg_write  out  1 each  register enables.
REQ-012 alu_src_a  out  2  ALU A select: 00 PC, 01 oldPC, 10 rs1, 11 zero.
REQ-013 alu_src_b  out  2  ALU B select: 00 rs2, 01 Imm, 10 constant 4.
REQ-014 result_src  out  2  result select: 00 ALU out register, 01 read data, 10 live ALU result.
REQ-015 aluop  out  2  ALU op class: 00 add, 01 sub, 10 decode from funct3/funct7b5.
REQ-016 immsrc  out  3  immediate-extender select: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-017 trap  out  1  an illegal opcode was decoded.
REQ-018 state  out  4  current state, for debug.

Function
REQ-019 The controller SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, TRAP=12.
REQ-020 Every output not listed for a state below SHALL be 0 in that state.
REQ-021 immsrc SHALL be decoded combinationally from op in every state:
- 0100011 → 001
- 1100011 → 010
- 1101111 → 011
- 0110111 → 100
- all other values → 000
REQ-022 FETCH outputs: mem_read=1, adr_src=0, a=00, b=10, aluop=00, result_src=10; ir_write=pc_write=mem_ready.
REQ-023 FETCH transitions: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-024 DECODE outputs: a=01, b=01, aluop=00 (branch/jump target precompute).
REQ-025 DECODE transitions, by op:
- 0000011 or 0100011 → MEMADR
- 0110011 → EXECR
- 0010011 → EXECI
- 1100011 → BEQ
- 1101111 → JAL
- 0110111 → LUI
- any other value → TRAP
REQ-026 MEMADR outputs: a=10, b=01, aluop=00. Next state is MEMREAD if op=0000011, else MEMWRITE.
REQ-027 MEMREAD outputs: mem_read=1, adr_src=1. Stay until mem_ready=1, then go to MEMWB.
REQ-028 MEMWB outputs: result_src=01, reg_write=1. Next state is FETCH.
REQ-029 MEMWRITE outputs: mem_write=1, adr_src=1. Stay until mem_ready=1, then go to FETCH.
REQ-030 EXECR outputs: a=10, b=00, aluop=10. EXECI outputs: a=10, b=01, aluop=10. Both go to ALUWB.
REQ-031 ALUWB outputs: result_src=00, reg_write=1. Next state is FETCH.
REQ-032 BEQ outputs: a=10, b=00, aluop=01, result_src=00. pc_write follows funct3:
- 000 → pc_write = zero
- 001 → pc_write = !zero
- any other value → pc_write = 0
BEQ then goes to FETCH.
REQ-033 JAL outputs: a=01, b=10, aluop=00, result_src=00, pc_write=1. Next state is ALUWB.
REQ-034 LUI outputs: a=11, b=01, aluop=00. Next state is ALUWB.
REQ-035 TRAP outputs: trap=1. TRAP is sticky and is left only by reset.
REQ-036 mem_ready SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE.
REQ-037 Latency without stalls SHALL be:
- load: 5 cycles
- store: 4 cycles
- R-type and I-type ALU: 4 cycles
- branch: 3 cycles
- JAL: 4 cycles
- LUI: 4 cycles
Each mem_ready=0 cycle SHALL add 1 cycle.

Reset
REQ-038 While rst_n=0: state=FETCH, and mem_read, mem_write, ir_write, pc_write, reg_write and trap SHALL be forced to 0 combinationally.
REQ-039 On rst_n deassertion, FETCH behaviour SHALL start at the next rising edge of clk.
REQ-040 Reset asserted in any state, including mid-stall or TRAP, SHALL abort the instruction with no further strobes.

Verification
REQ-041 op=0000011, mem_ready=1 every cycle → states 0,1,2,3,4,0; reg_write=1 only in state 4; immsrc=000.
REQ-042 op=0100011, mem_ready low for 2 cycles in MEMWRITE → mem_write high for 3 cycles, adr_src=1, immsrc=001, then FETCH.
REQ-043 op=1100011: funct3=000 with zero=1 → pc_write=1 in BEQ; funct3=001 with zero=1 → pc_write=0; immsrc=010.
REQ-044 op=1101111 → states 0,1,10,8,0; pc_write=1 in JAL; immsrc=011. op=0110111 → states 0,1,11,8,0 with a=11 and immsrc=100.
REQ-045 op=1111111 → TRAP, trap=1 held for 20 cycles; rst_n pulse → state=0, trap=0.
REQ-046 rst_n asserted in MEMREAD with mem_ready=0 → all strobes 0 immediately; state=0 after reset is released.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller: Moore FSM sequencing fetch, decode,
// memory access, ALU execute, branch, JAL and LUI, plus a sticky trap
// state for illegal opcodes.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   op, funct3          instruction fields instr[6:0], instr[14:12]
//   funct7b5            instr[30], consumed by the ALU decoder, not here
//   zero                ALU zero flag, meaningful in BEQ
//   mem_ready           memory finishes the pending read/write this cycle
//   mem_read/mem_write  memory strobes, held until mem_ready
//   adr_src             memory address select (0 PC, 1 ALU out register)
//   ir_write, pc_write, reg_write  register enables
//   alu_src_a/b, result_src, aluop, immsrc  datapath selects
//   trap                illegal opcode decoded (sticky until reset)
//   state               current state, for debug
//
// state    | meaning
// ---------+------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | read registers, precompute branch/jump target
// MEMADR   | compute load/store address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, wait for mem_ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALU out register to rd
// BEQ      | compare rs1/rs2, conditionally load PC
// JAL      | PC <= target, ALU computes oldPC + 4 for rd
// LUI      | ALU passes the U immediate
// TRAP     | illegal opcode, held until reset

module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] aluop,
    output logic [2:0] immsrc,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t state_q, state_d;

    // funct7b5 feeds the ALU decoder directly; the controller only carries it.
    logic unused_funct7b5;
    assign unused_funct7b5 = funct7b5;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        case (op)
            OP_STORE: immsrc = 3'b001;
            OP_BEQ:   immsrc = 3'b010;
            OP_JAL:   immsrc = 3'b011;
            OP_LUI:   immsrc = 3'b100;
            default:  immsrc = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        aluop      = 2'b00;
        trap       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                aluop     = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluop     = 2'b01;
                // funct3 000 is BEQ, 001 is BNE; other branch kinds never redirect.
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = ~zero;
                    default: pc_write = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes must drop the moment reset asserts, not at the next edge.
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            trap      = 1'b0;
        end
    end

endmodule
